relu_backward_sched: RTL and testbench

//  Sequences one ReLU-backward job through the WIDTH-lane relu backward vector layer: accepts a

---
 rtl/relu_backward_sched.sv | 199 +++++++++++++++++++
 tb/tb_relu_backward_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_backward_sched.sv
// relu_backward_sched
//   Runs one ReLU-backward job at a time through the WIDTH-lane relu backward
//   vector layer. A command gives a source base, a destination base, a length
//   and an id. The block issues one source read per non-held cycle. Each read
//   is tracked through memory plus layer latency with a valid shift register,
//   and a destination write is raised when the read's result leaves the layer.
//   When the job is finished, done pulses for one cycle carrying the job id.
//
//   Optional feature macro: RELU_BWD_PERF_EN
//     defined   : perf_cycles / perf_hold are saturating job counters
//     undefined : perf_cycles / perf_hold are tied to zero
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_src/dst/len/id      job source base, destination base, length, id
//   hold                    pauses read issue; in-flight vectors keep moving
//   rd_en/rd_addr           source memory read strobe and address
//   layer_id/layer_id_in    id sent to the layer / id echoed back by the layer
//   wr_en/wr_addr           destination write strobe and address
//   busy                    a job is active (issue, drain or done)
//   done/done_id            one-cycle completion pulse and the job id
//   id_err                  sticky echoed-id mismatch, cleared on accept
//   perf_cycles/perf_hold   job cycle count / held-issue cycle count
module relu_backward_sched #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [7:0]        cmd_id,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        layer_id,
  input  logic [7:0]        layer_id_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic [7:0]        done_id,
  output logic              id_err,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_hold
);

  localparam int unsigned L = MEM_LAT + PIPE_LAT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_raddr;
  logic [ADDR_W-1:0] r_waddr;
  logic [LEN_W-1:0]  r_rem;
  logic [7:0]        r_id;
  logic              r_id_err;
  logic [L-1:0]      r_vld;

  logic [L-1:0]      w_vld_sh;
  logic [L-1:0]      w_vld_nxt;
  logic              w_accept;
  logic              w_rd_en;
  logic              w_wr_en;
  logic              w_busy;
  logic              w_done;

  assign w_accept  = cmd_valid & (r_state == S_IDLE);
  assign w_wr_en   = r_vld[L-1];
  // Shifted-only image of the tracker; while draining no new read enters, so
  // an all-zero shift means the last write is happening this cycle.
  assign w_vld_sh  = r_vld << 1;
  assign w_vld_nxt = w_vld_sh | L'(w_rd_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_accept) begin
          w_state_nxt = (cmd_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_rd_en = ~hold;
        if (w_rd_en && (r_rem == LEN_W'(1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_vld_sh == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_raddr  <= '0;
      r_waddr  <= '0;
      r_rem    <= '0;
      r_id     <= '0;
      r_id_err <= 1'b0;
      r_vld    <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      if (w_accept) begin
        r_raddr  <= cmd_src;
        r_waddr  <= cmd_dst;
        r_rem    <= cmd_len;
        r_id     <= cmd_id;
        r_id_err <= 1'b0;
      end else begin
        if (w_rd_en) begin
          r_raddr <= r_raddr + ADDR_W'(1);
          r_rem   <= r_rem - LEN_W'(1);
        end
        if (w_wr_en) begin
          r_waddr <= r_waddr + ADDR_W'(1);
          if (layer_id_in != r_id) begin
            r_id_err <= 1'b1;
          end
        end
      end
    end
  end

  assign cmd_ready = ~w_busy;
  assign busy      = w_busy;
  assign rd_en     = w_rd_en;
  assign rd_addr   = w_rd_en ? r_raddr : '0;
  assign wr_en     = w_wr_en;
  assign wr_addr   = w_wr_en ? r_waddr : '0;
  assign layer_id  = w_busy ? r_id : '0;
  assign done      = w_done;
  assign done_id   = w_done ? r_id : '0;
  assign id_err    = r_id_err;

`ifdef RELU_BWD_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cycles <= '0;
      r_perf_hold   <= '0;
    end else if (w_accept) begin
      r_perf_cycles <= '0;
      r_perf_hold   <= '0;
    end else begin
      if (w_busy && (r_perf_cycles != '1)) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
      if ((r_state == S_ISSUE) && hold && (r_perf_hold != '1)) begin
        r_perf_hold <= r_perf_hold + 32'd1;
      end
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_hold   = r_perf_hold;
`else
  assign perf_cycles = '0;
  assign perf_hold   = '0;
`endif

endmodule

// File: tb/tb_relu_backward_sched.sv
// Testbench for relu_backward_sched: table of directed jobs followed by
// randomized jobs, each checked against a job-level reference model.
module tb_relu_backward_sched;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_src;
  logic [15:0] cmd_dst;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_id;
  logic        hold;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  layer_id;
  logic [7:0]  layer_id_in;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic        busy;
  logic        done;
  logic [7:0]  done_id;
  logic        id_err;
  logic [31:0] perf_cycles;
  logic [31:0] perf_hold;

  always #5 clk = ~clk;

  relu_backward_sched #(
    .ADDR_W  (16),
    .LEN_W   (16),
    .MEM_LAT (2),
    .PIPE_LAT(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .cmd_id     (cmd_id),
    .hold       (hold),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .layer_id   (layer_id),
    .layer_id_in(layer_id_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .id_err     (id_err),
    .perf_cycles(perf_cycles),
    .perf_hold  (perf_hold)
  );

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    int          len;
    logic [7:0]  id;
    logic [63:0] hold_mask;  // bit c = hold during cycle c after accept
    int          bad_idx;    // write index whose echoed id is corrupted, -1 none
    int          rst_cyc;    // cycle with reset asserted, -1 none
    bit          spam;       // extra commands offered in cycles 1..3
    int          exp_done;   // done cycle, -1 none
    logic        exp_id_err;
    int          exp_pc;
    int          exp_ph;
  } job_t;

  int n_pass  = 0;
  int n_total = 0;
  int job_no  = 0;

  int          m_rd_c[$];
  logic [15:0] m_rd_a[$];
  int          m_wr_c[$];
  logic [15:0] m_wr_a[$];
  int          m_done;
  int          m_hold_cnt;

  int          l_rd_c[$];
  logic [15:0] l_rd_a[$];
  int          l_wr_c[$];
  logic [15:0] l_wr_a[$];
  int          l_done_c[$];
  logic [7:0]  l_done_id[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL job%0d %s: actual %0d required %0d", job_no, name, act, exp);
  endtask

  // Reference: reads land on the non-held cycles from cycle 1 on, each write
  // follows its read by LAT cycles, done follows the last write. A reset
  // discards every event after the reset cycle.
  task automatic model(input job_t j);
    int k;
    int c;
    m_rd_c.delete(); m_rd_a.delete(); m_wr_c.delete(); m_wr_a.delete();
    k = 0;
    c = 1;
    m_hold_cnt = 0;
    while (k < j.len) begin
      if (c < 64 && j.hold_mask[c]) begin
        m_hold_cnt++;
      end else begin
        m_rd_c.push_back(c);
        m_rd_a.push_back(j.src + 16'(k));
        k++;
      end
      c++;
    end
    foreach (m_rd_c[i]) begin
      m_wr_c.push_back(m_rd_c[i] + LAT);
      m_wr_a.push_back(j.dst + 16'(i));
    end
    m_done = (j.len == 0) ? 1 : m_wr_c[m_wr_c.size()-1] + 1;
    if (j.rst_cyc >= 0) begin
      while (m_rd_c.size() > 0 && m_rd_c[m_rd_c.size()-1] > j.rst_cyc) begin
        void'(m_rd_c.pop_back()); void'(m_rd_a.pop_back());
      end
      while (m_wr_c.size() > 0 && m_wr_c[m_wr_c.size()-1] > j.rst_cyc) begin
        void'(m_wr_c.pop_back()); void'(m_wr_a.pop_back());
      end
      if (m_done > j.rst_cyc) m_done = -1;
      m_hold_cnt = 0;
    end
  endtask

  function automatic int seq_mism(input int ac[$], input logic [15:0] aa[$],
                                  input int ec[$], input logic [15:0] ea[$]);
    int n;
    int m;
    n = (ac.size() < ec.size()) ? ac.size() : ec.size();
    m = (ac.size() > ec.size()) ? ac.size() - ec.size() : ec.size() - ac.size();
    for (int i = 0; i < n; i++) begin
      if (ac[i] != ec[i] || aa[i] != ea[i]) m++;
    end
    return m;
  endfunction

  // Entered just after a rising edge with the DUT idle; leaves it the same way.
  task automatic run_job(input job_t j);
    int   end_c;
    int   last_c;
    int   wr_seen;
    int   ctrl_err;
    logic in_job;
    logic ready0;
    logic ierr_c1;
    logic ierr_last;
    logic [31:0] pc_last;
    logic [31:0] ph_last;
    longint done_act;
    model(j);
    l_rd_c.delete(); l_rd_a.delete(); l_wr_c.delete(); l_wr_a.delete();
    l_done_c.delete(); l_done_id.delete();
    end_c  = (j.rst_cyc >= 0) ? j.rst_cyc : m_done;
    last_c = (j.rst_cyc >= 0) ? j.rst_cyc + 10 : m_done + 1;
    if (last_c < 2) last_c = 2;
    if (last_c > 300) last_c = 300;
    wr_seen = 0; ctrl_err = 0; ready0 = 1'b0; ierr_c1 = 1'b1;
    ierr_last = 1'b0; pc_last = '0; ph_last = '0;
    for (int c = 0; c <= last_c; c++) begin
      if (c == 0) begin
        cmd_valid = 1'b1; cmd_src = j.src; cmd_dst = j.dst;
        cmd_len = 16'(j.len); cmd_id = j.id;
      end else if (j.spam && c <= 3) begin
        cmd_valid = 1'b1; cmd_src = 16'($urandom); cmd_dst = 16'($urandom);
        cmd_len = 16'($urandom_range(1, 9)); cmd_id = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      hold        = (c < 64) ? j.hold_mask[c] : 1'b0;
      reset       = (c == j.rst_cyc);
      layer_id_in = j.id;
      @(negedge clk);
      if (c == 0) ready0 = cmd_ready;
      if (c == 1) ierr_c1 = id_err;
      if (rd_en) begin l_rd_c.push_back(c); l_rd_a.push_back(rd_addr); end
      if (wr_en) begin
        l_wr_c.push_back(c); l_wr_a.push_back(wr_addr);
        if (wr_seen == j.bad_idx) layer_id_in = j.id ^ 8'h04;
        wr_seen++;
      end
      if (done) begin l_done_c.push_back(c); l_done_id.push_back(done_id); end
      in_job = (c >= 1 && c <= end_c);
      if (busy !== in_job || cmd_ready !== !in_job ||
          layer_id !== (in_job ? j.id : 8'h00)) ctrl_err++;
      ierr_last = id_err; pc_last = perf_cycles; ph_last = perf_hold;
      @(posedge clk); #1;
      reset = 1'b0;
    end
    cmd_valid = 1'b0;
    hold      = 1'b0;

    chk("ready_at_accept", ready0, 1);
    chk("id_err_cleared_on_accept", ierr_c1, 0);
    chk("ctrl_per_cycle_errors", ctrl_err, 0);
    chk("rd_seq_mismatches", seq_mism(l_rd_c, l_rd_a, m_rd_c, m_rd_a), 0);
    chk("wr_seq_mismatches", seq_mism(l_wr_c, l_wr_a, m_wr_c, m_wr_a), 0);
    if (l_done_c.size() == 1) done_act = l_done_c[0];
    else if (l_done_c.size() == 0) done_act = -1;
    else done_act = -100 - l_done_c.size();
    chk("done_cycle", done_act, j.exp_done);
    chk("model_done_cycle", done_act, m_done);
    if (l_done_id.size() > 0) chk("done_id", l_done_id[0], j.id);
    chk("id_err_final", ierr_last, j.exp_id_err);
`ifdef RELU_BWD_PERF_EN
    chk("perf_cycles", pc_last, j.exp_pc);
    chk("perf_hold", ph_last, j.exp_ph);
`else
    chk("perf_cycles", pc_last, 0);
    chk("perf_hold", ph_last, 0);
`endif
  endtask

  job_t tbl[8];
  job_t rj;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    cmd_id = '0; hold = 1'b0; layer_id_in = '0;

    //        src      dst      len id     hold_mask  bad rst spam done ierr pc  ph
    tbl[0] = '{16'h0010, 16'h0080, 4, 8'h05, 64'h0,    -1, -1, 0,  8, 0,  8, 0};
    tbl[1] = '{16'h0010, 16'h0080, 4, 8'h05, 64'hC,    -1, -1, 0, 10, 0, 10, 2};
    tbl[2] = '{16'h0010, 16'h0080, 0, 8'h09, 64'h0,    -1, -1, 0,  1, 0,  1, 0};
    tbl[3] = '{16'hFFFE, 16'hFFFF, 3, 8'h21, 64'h0,    -1, -1, 0,  7, 0,  7, 0};
    tbl[4] = '{16'h0200, 16'h0300, 8, 8'h11, 64'h0,    -1,  3, 0, -1, 0,  0, 0};
    tbl[5] = '{16'h0040, 16'h0050, 2, 8'h07, 64'h0,     0, -1, 0,  6, 1,  6, 0};
    tbl[6] = '{16'h1234, 16'h4321, 5, 8'h33, 64'h0,    -1, -1, 1,  9, 0,  9, 0};
    tbl[7] = '{16'h0A00, 16'h0B00, 1, 8'h44, 64'h2,    -1, -1, 0,  6, 0,  6, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {rd_en, rd_addr, layer_id, wr_en, wr_addr, busy, done,
                          done_id, id_err, cmd_ready}, 1);
    chk("reset_perf", {perf_cycles, perf_hold}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int t = 0; t < 8; t++) begin
      job_no = t + 1;
      run_job(tbl[t]);
    end

    for (int r = 0; r < 12; r++) begin
      job_no      = 100 + r;
      rj.src      = 16'($urandom);
      rj.dst      = 16'($urandom);
      rj.len      = $urandom_range(0, 12);
      rj.id       = 8'($urandom);
      rj.hold_mask = {$urandom & $urandom, $urandom & $urandom};
      rj.bad_idx  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rj.len) : -1;
      rj.rst_cyc  = -1;
      rj.spam     = ($urandom_range(0, 3) == 0);
      model(rj);
      rj.exp_done   = m_done;
      rj.exp_id_err = (rj.bad_idx >= 0 && rj.bad_idx < rj.len);
      rj.exp_pc     = m_done;
      rj.exp_ph     = m_hold_cnt;
      run_job(rj);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
